dmem_arbiter: RTL and testbench

- Two-port arbiter and access sequencer in front of the single-port data memory (`dmem`).
- Port m0 is the CPU load/store unit; port m1 is a secondary master (debug/DMA loader).
- Grants one request at a time, drives the memory's write-enable, read-enable, address, access-type and write-data inputs for exactly one cycle, and returns a registered response.
- Rejects misaligned accesses with an error instead of touching memory.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arbiter_rr_arb2.sv | 46 ++++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
  typedef enum logic {P_M0, P_M1} port_t;

  // Size code 2'b11 is reserved and decoded as a word, like the dmem itself.
  function automatic logic addr_aligned(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus response pulse.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_type, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_type, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request grant logic: round-robin (ARB_MODE=0) or fixed m0 priority (ARB_MODE=1).
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  port_t last_grant;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (ARB_MODE == 1) begin
        gnt0 = req0;
        gnt1 = req1 && !req0;
      end else if (req0 && req1) begin
        gnt0 = (last_grant == P_M1);
        gnt1 = (last_grant == P_M0);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // A grant always coincides with a handshake, so it is recorded directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= P_M1;
    end else if (gnt0) begin
      last_grant <= P_M0;
    end else if (gnt1) begin
      last_grant <= P_M1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer in front of the single-port dmem.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ARB_MODE = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_rw_type,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic              gnt0, gnt1;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [2:0]        l_type;
  logic [DATA_W-1:0] l_wdata;
  port_t             l_port;
  logic              aligned;
  logic              access;
  logic [DATA_W-1:0] rd_value;

  logic              rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;

  rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_IDLE),
    .req0 (m0.req_valid),
    .req1 (m1.req_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign m0.req_ready = gnt0;
  assign m1.req_ready = gnt1;
  assign m0.rsp_valid = rsp0_valid;
  assign m0.rsp_err   = rsp0_err;
  assign m0.rsp_rdata = rsp0_rdata;
  assign m1.rsp_valid = rsp1_valid;
  assign m1.rsp_err   = rsp1_err;
  assign m1.rsp_rdata = rsp1_rdata;

  assign access   = (state == ST_ACCESS);
  assign aligned  = addr_aligned(l_addr[1:0], l_type[1:0]);
  assign rd_value = mem_ren ? mem_rdata : '0;

  // Memory strobes are decoded from the state register so an async reset drops them at once.
  always_comb begin
    mem_wen     = 1'b0;
    mem_ren     = 1'b0;
    mem_addr    = '0;
    mem_rw_type = '0;
    mem_wdata   = '0;
    if (access) begin
      mem_wen     = l_we && aligned;
      mem_ren     = !l_we && aligned;
      mem_addr    = l_addr;
      mem_rw_type = l_type;
      mem_wdata   = l_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_type     <= '0;
      l_wdata    <= '0;
      l_port     <= P_M0;
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt0) begin
            l_we    <= m0.req_we;
            l_addr  <= m0.req_addr;
            l_type  <= m0.req_type;
            l_wdata <= m0.req_wdata;
            l_port  <= P_M0;
            state   <= ST_ACCESS;
          end else if (gnt1) begin
            l_we    <= m1.req_we;
            l_addr  <= m1.req_addr;
            l_type  <= m1.req_type;
            l_wdata <= m1.req_wdata;
            l_port  <= P_M1;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (l_port == P_M0) begin
            rsp0_valid <= 1'b1;
            rsp0_err   <= !aligned;
            rsp0_rdata <= rd_value;
          end else begin
            rsp1_valid <= 1'b1;
            rsp1_err   <= !aligned;
            rsp1_rdata <= rd_value;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural dmem model and a fixed-priority instance.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();
  dmem_arbiter_if fbus0 ();
  dmem_arbiter_if fbus1 ();

  logic        mem_wen, mem_ren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_rw_type;
  logic        f_mem_wen, f_mem_ren;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [31:0] f_mem_rdata = '0;
  logic [2:0]  f_mem_rw_type;

  dmem_arbiter #(.ARB_MODE(0), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .m0(bus0), .m1(bus1),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rw_type(mem_rw_type), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ARB_MODE(1), .ADDR_W(32), .DATA_W(32)) dut_fix (
    .clk(clk), .rst(rst), .m0(fbus0), .m1(fbus1),
    .mem_wen(f_mem_wen), .mem_ren(f_mem_ren), .mem_addr(f_mem_addr),
    .mem_rw_type(f_mem_rw_type), .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
  );

  // Behavioural dmem: combinational read, write on the rising edge.
  logic [31:0] mem_arr [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [31:0] sh;
    case (t[1:0])
      2'b00: begin
        sh = w >> {a, 3'b000};
        return t[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = w >> {a[1], 4'b0000};
        return t[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (t[1:0])
      2'b00:   r[{a, 3'b000} +: 8]   = d[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_idx] <= bd_data;
    else if (mem_wen) mem_arr[mem_addr[11:2]] <= store_merge(mem_arr[mem_addr[11:2]], mem_addr[1:0], mem_rw_type, mem_wdata);
  end

  always_comb mem_rdata = load_ext(mem_arr[mem_addr[11:2]], mem_addr[1:0], mem_rw_type);

  // Scoreboard state
  typedef struct { logic we; logic [31:0] addr; logic [2:0] typ; logic [31:0] wdata; } req_t;
  typedef struct { int port; logic wen; logic ren; logic [31:0] addr; logic [2:0] typ; logic [31:0] wdata; } acc_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;

  req_t sq0[$], sq1[$];
  acc_t acc_q[$];
  rsp_t rq0[$], rq1[$];
  int   hsc0[$], hsc1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  bit   pend = 1'b0;
  acc_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic req(input int port, input logic we, input logic [31:0] addr, input logic [2:0] typ,
                     input logic [31:0] wdata, input logic wen, input logic ren,
                     input logic [31:0] rdata, input logic err);
    req_t r;
    acc_t a;
    rsp_t s;
    r = '{we, addr, typ, wdata};
    a = '{port, wen, ren, addr, typ, wdata};
    s = '{rdata, err};
    acc_q.push_back(a);
    if (port == 0) begin sq0.push_back(r); rq0.push_back(s); end
    else begin sq1.push_back(r); rq1.push_back(s); end
  endtask

  task automatic apply_fronts();
    if (sq0.size() > 0) begin
      bus0.req_valid = 1'b1; bus0.req_we = sq0[0].we; bus0.req_addr = sq0[0].addr;
      bus0.req_type = sq0[0].typ; bus0.req_wdata = sq0[0].wdata;
    end else begin
      bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_type = '0; bus0.req_wdata = '0;
    end
    if (sq1.size() > 0) begin
      bus1.req_valid = 1'b1; bus1.req_we = sq1[0].we; bus1.req_addr = sq1[0].addr;
      bus1.req_type = sq1[0].typ; bus1.req_wdata = sq1[0].wdata;
    end else begin
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_type = '0; bus1.req_wdata = '0;
    end
  endtask

  // Present queued requests until all are accepted; first_hs is the cycle of the first handshake.
  task automatic drive_all(input int budget, output int first_hs);
    int cyc;
    bit hs0, hs1;
    cyc = 0;
    first_hs = -1;
    apply_fronts();
    while (sq0.size() > 0 || sq1.size() > 0) begin
      if (cyc >= budget) begin
        bad("handshake_timeout");
        sq0.delete();
        sq1.delete();
        break;
      end
      @(negedge clk);
      hs0 = bus0.req_valid && bus0.req_ready;
      hs1 = bus1.req_valid && bus1.req_ready;
      @(posedge clk);
      #1;
      if ((hs0 || hs1) && first_hs < 0) first_hs = cyc;
      if (hs0) void'(sq0.pop_front());
      if (hs1) void'(sq1.pop_front());
      apply_fronts();
      cyc++;
    end
  endtask

  // Monitor: memory-side and response-side comparisons against the queues.
  always @(negedge clk) begin
    rsp_t s;
    int   h;
    cyc_n++;
    if (rst) begin
      pend = 1'b0;
      hsc0.delete();
      hsc1.delete();
    end else begin
      if (pend) begin
        chk("mem_wen", mem_wen, cur.wen);
        chk("mem_ren", mem_ren, cur.ren);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_rw_type", mem_rw_type, cur.typ);
        chk("mem_wdata", mem_wdata, cur.wdata);
        pend = 1'b0;
      end else begin
        chk("mem_idle_strobes", {mem_wen, mem_ren}, 2'b00);
      end
      if (bus0.req_ready && bus1.req_ready) bad("double_ready");
      if ((bus0.req_valid && bus0.req_ready) || (bus1.req_valid && bus1.req_ready)) begin
        if (acc_q.size() == 0) bad("unexpected_handshake");
        else begin
          cur = acc_q.pop_front();
          chk("grant_port", (bus1.req_valid && bus1.req_ready) ? 1 : 0, cur.port);
          pend = 1'b1;
          if (bus0.req_valid && bus0.req_ready) hsc0.push_back(cyc_n);
          else hsc1.push_back(cyc_n);
        end
      end
      if (bus0.rsp_valid) begin
        if (rq0.size() == 0 || hsc0.size() == 0) bad("unexpected_m0_rsp");
        else begin
          s = rq0.pop_front();
          h = hsc0.pop_front();
          chk("m0_rsp_rdata", bus0.rsp_rdata, s.rdata);
          chk("m0_rsp_err", bus0.rsp_err, s.err);
          chk("m0_rsp_latency", cyc_n - h, 2);
        end
      end
      if (bus1.rsp_valid) begin
        if (rq1.size() == 0 || hsc1.size() == 0) bad("unexpected_m1_rsp");
        else begin
          s = rq1.pop_front();
          h = hsc1.pop_front();
          chk("m1_rsp_rdata", bus1.rsp_rdata, s.rdata);
          chk("m1_rsp_err", bus1.rsp_err, s.err);
          chk("m1_rsp_latency", cyc_n - h, 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic backdoor(input logic [9:0] idx, input logic [31:0] d);
    @(posedge clk);
    #1;
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  initial begin
    int fh, n;
    bit got;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_type = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_type = '0; bus1.req_wdata = '0;
    fbus0.req_valid = 1'b0; fbus0.req_we = 1'b0; fbus0.req_addr = '0; fbus0.req_type = '0; fbus0.req_wdata = '0;
    fbus1.req_valid = 1'b0; fbus1.req_we = 1'b0; fbus1.req_addr = '0; fbus1.req_type = '0; fbus1.req_wdata = '0;

    backdoor(10'd64, 32'hDEADBEEF);   // 0x100
    backdoor(10'd128, 32'h0000_0000); // 0x200
    backdoor(10'd192, 32'hCAFEF00D);  // 0x300
    @(negedge clk);
    chk("rst_m0_rsp_valid", bus0.rsp_valid, 1'b0);
    chk("rst_m1_rsp_valid", bus1.rsp_valid, 1'b0);
    chk("rst_m0_rsp_err", bus0.rsp_err, 1'b0);
    chk("rst_m0_rsp_rdata", bus0.rsp_rdata, 32'h0);
    chk("rst_mem_strobes", {mem_wen, mem_ren}, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // m0 word load straight out of reset
    req(0, 1'b0, 32'h100, RW_W, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    drive_all(10, fh);
    chk("first_ready_cycle", fh, 0);
    repeat (3) @(posedge clk);
    #1;

    // Both ports valid; last grant was m0, so m1 goes first and they alternate
    req(1, 1'b0, 32'h102, RW_H,  32'h0, 1'b0, 1'b1, 32'hFFFFDEAD, 1'b0);
    req(0, 1'b0, 32'h100, RW_W,  32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    req(1, 1'b0, 32'h100, RW_HU, 32'h0, 1'b0, 1'b1, 32'h0000BEEF, 1'b0);
    req(0, 1'b0, 32'h100, RW_BU, 32'h0, 1'b0, 1'b1, 32'h000000EF, 1'b0);
    drive_all(20, fh);
    repeat (3) @(posedge clk);
    #1;

    // Byte store from m1, then back-to-back word load from m0
    req(1, 1'b1, 32'h203, RW_B, 32'h0000_00A5, 1'b1, 1'b0, 32'h0, 1'b0);
    req(0, 1'b0, 32'h200, RW_W, 32'h0, 1'b0, 1'b1, 32'hA500_0000, 1'b0);
    drive_all(20, fh);

    // Misaligned half load, misaligned word store (must not write), then reserved-type load
    req(0, 1'b0, 32'h103, RW_H, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    req(0, 1'b1, 32'h201, RW_W, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b1);
    req(0, 1'b0, 32'h200, 3'b011, 32'h0, 1'b0, 1'b1, 32'hA500_0000, 1'b0);
    drive_all(20, fh);

    // Sign and zero extension of a byte
    req(1, 1'b1, 32'h100, RW_W, 32'h0000_8000, 1'b1, 1'b0, 32'h0, 1'b0);
    req(0, 1'b0, 32'h101, RW_BU, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    req(0, 1'b0, 32'h101, RW_B,  32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0);
    drive_all(20, fh);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a store's ACCESS cycle
    acc_q.push_back('{0, 1'b1, 1'b0, 32'h300, RW_W, 32'h1234_5678});
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h300;
    bus0.req_type = RW_W; bus0.req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst_test_ready", bus0.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_type = '0;
    chk("rst_test_wen_before", mem_wen, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_test_wen_drop", mem_wen, 1'b0);
    chk("rst_test_rsp_valid", bus0.rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req(0, 1'b0, 32'h300, RW_W, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    drive_all(10, fh);
    chk("post_rst_ready_cycle", fh, 0);
    repeat (3) @(posedge clk);
    #1;

    // Fixed-priority instance: m0 takes every grant while valid
    fbus0.req_valid = 1'b1; fbus0.req_addr = 32'h10; fbus0.req_type = RW_BU;
    fbus1.req_valid = 1'b1; fbus1.req_addr = 32'h20; fbus1.req_type = RW_BU;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fix_m1_blocked", fbus1.req_ready, 1'b0);
      if (fbus0.req_valid && fbus0.req_ready) n++;
      if (i == 1) begin
        chk("fix_mem_ren", {f_mem_wen, f_mem_ren}, 2'b01);
        chk("fix_mem_addr", f_mem_addr, 32'h10);
        chk("fix_mem_type", f_mem_rw_type, RW_BU);
        chk("fix_mem_wdata", f_mem_wdata, 32'h0);
      end
      if (i == 2) begin
        chk("fix_m0_rsp_valid", fbus0.rsp_valid, 1'b1);
        chk("fix_m0_rsp", {fbus0.rsp_err, fbus0.rsp_rdata}, 33'h0);
      end
    end
    chk("fix_m0_grants", n, 3);
    @(posedge clk);
    #1;
    fbus0.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (fbus1.req_valid && fbus1.req_ready) got = 1'b1;
    end
    chk("fix_m1_granted", got, 1'b1);
    @(posedge clk);
    #1;
    fbus1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fix_m1_rsp_valid", fbus1.rsp_valid, 1'b1);
    chk("fix_m1_rsp", {fbus1.rsp_err, fbus1.rsp_rdata}, 33'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("acc_q_drained", acc_q.size(), 0);
    chk("m0_rsp_q_drained", rq0.size(), 0);
    chk("m1_rsp_q_drained", rq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
